// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the sipo_deser serial-to-parallel deserialiser.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam bit MSB_FIRST = 1'b0;
    localparam bit LSB_FIRST = 1'b1;

    // Counter width for a WIDTH-bit word; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; flags the shift that completes a word and exposes that word.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = MSB_FIRST,
    parameter int CW        = cnt_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             in_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic [CW-1:0]    bitcnt_o,
    output logic             word_done_o,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             last_s;

    // Post-shift value and wrapped count for the current edge.
    always_comb begin
        if (LSB_FIRST != MSB_FIRST) begin
            q_d = {in_i, q_q[WIDTH-1:1]};
        end else begin
            q_d = {q_q[WIDTH-2:0], in_i};
        end
        last_s = (cnt_q == CW'(WIDTH - 1));
        if (last_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Shift state: reset and frame restart both empty the register.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end else begin
            q_q   <= q_q;
            cnt_q <= cnt_q;
        end
    end

    assign q_o         = q_q;
    assign bitcnt_o    = cnt_q;
    assign word_done_o = en_i & ~clr_i & ~rst_i & last_s;
    assign word_o      = q_d;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser: framed words held on DOUT with valid/ready and sticky overrun.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = MSB_FIRST
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        EN,
    input  logic                        IN,
    input  logic                        CLR,
    output logic [WIDTH-1:0]            Q,
    output logic [cnt_width(WIDTH)-1:0] BITCNT,
    output logic [WIDTH-1:0]            DOUT,
    output logic                        DVALID,
    input  logic                        DREADY,
    output logic                        OVR
);

    localparam int CW = cnt_width(WIDTH);

    logic             word_done_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             dvalid_q;
    logic             dvalid_d;
    logic             ovr_q;
    logic             ovr_d;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST),
        .CW        (CW)
    ) u_core (
        .clk_i       (CLK),
        .rst_i       (RST),
        .en_i        (EN),
        .in_i        (IN),
        .clr_i       (CLR),
        .q_o         (Q),
        .bitcnt_o    (BITCNT),
        .word_done_o (word_done_s),
        .word_o      (word_s)
    );

    // Output word handshake: a completion loads only if the slot is free or being consumed.
    always_comb begin
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        ovr_d    = ovr_q;
        if (word_done_s) begin
            if (!dvalid_q || DREADY) begin
                dout_d   = word_s;
                dvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (dvalid_q && DREADY) begin
            dvalid_d = 1'b0;
        end else begin
            dvalid_d = dvalid_q;
        end
        if (CLR) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_d;
        end
    end

    // Output holding registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign OVR    = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser at WIDTH=4, MSB-first and LSB-first instances sharing one stimulus.
module tb_sipo_deser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         din = 1'b0;
    logic         clr = 1'b0;
    logic         dready = 1'b0;

    logic [W-1:0] m_q, m_dout, l_q, l_dout;
    logic [1:0]   m_cnt, l_cnt;
    logic         m_dvalid, m_ovr, l_dvalid, l_ovr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .CLK(clk), .RST(rst), .EN(en), .IN(din), .CLR(clr),
        .Q(m_q), .BITCNT(m_cnt), .DOUT(m_dout), .DVALID(m_dvalid),
        .DREADY(dready), .OVR(m_ovr)
    );

    sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .CLK(clk), .RST(rst), .EN(en), .IN(din), .CLR(clr),
        .Q(l_q), .BITCNT(l_cnt), .DOUT(l_dout), .DVALID(l_dvalid),
        .DREADY(dready), .OVR(l_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge with the given inputs, then settle past the edge.
    task automatic step(input logic e, input logic b, input logic c, input logic r, input logic s);
        en = e; din = b; clr = c; dready = r; rst = s;
        @(posedge clk);
        #1;
        en = 1'b0; din = 1'b0; clr = 1'b0; dready = 1'b0; rst = 1'b0;
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_q", 32'(m_q), 32'h0);
        chk("rst_cnt", 32'(m_cnt), 32'h0);
        chk("rst_dout", 32'(m_dout), 32'h0);
        chk("rst_dvalid", 32'(m_dvalid), 32'h0);
        chk("rst_ovr", 32'(m_ovr), 32'h0);

        // Stream 1,0,1,1
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_cnt", 32'(m_cnt), 32'h2);
        chk("mid_q_msb", 32'(m_q), 32'h2);
        chk("mid_q_lsb", 32'(l_q), 32'h4);
        chk("mid_dvalid", 32'(m_dvalid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("w1_dout_msb", 32'(m_dout), 32'hB);
        chk("w1_dout_lsb", 32'(l_dout), 32'hD);
        chk("w1_dvalid", 32'(m_dvalid), 32'h1);
        chk("w1_cnt", 32'(m_cnt), 32'h0);

        // Consume with no completion: DOUT keeps stale value
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cons_dvalid", 32'(m_dvalid), 32'h0);
        chk("cons_dout", 32'(m_dout), 32'hB);

        // Backpressure: 1010 then 0101 with DREADY low
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp1_dout_msb", 32'(m_dout), 32'hA);
        chk("bp1_dout_lsb", 32'(l_dout), 32'h5);
        chk("bp1_ovr", 32'(m_ovr), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp2_dout", 32'(m_dout), 32'hA);
        chk("bp2_dvalid", 32'(m_dvalid), 32'h1);
        chk("bp2_ovr_msb", 32'(m_ovr), 32'h1);
        chk("bp2_ovr_lsb", 32'(l_ovr), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp3_dvalid", 32'(m_dvalid), 32'h0);
        chk("bp3_ovr", 32'(m_ovr), 32'h1);

        // Pending word 1111, then CLR with EN on the same edge
        for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pend_dout", 32'(m_dout), 32'hF);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("clren_cnt", 32'(m_cnt), 32'h0);
        chk("clren_q", 32'(m_q), 32'h0);
        chk("clren_ovr", 32'(m_ovr), 32'h0);
        chk("clren_dvalid", 32'(m_dvalid), 32'h1);
        chk("clren_dout", 32'(m_dout), 32'hF);

        // Completion of 0011 with DREADY on the same edge
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sim_dout_msb", 32'(m_dout), 32'h3);
        chk("sim_dout_lsb", 32'(l_dout), 32'hC);
        chk("sim_dvalid", 32'(m_dvalid), 32'h1);
        chk("sim_ovr", 32'(m_ovr), 32'h0);

        // CLR does not block a handshake
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("clrhs_dvalid", 32'(m_dvalid), 32'h0);
        chk("clrhs_dout", 32'(m_dout), 32'h3);

        // CLR mid-word: 1,1, CLR, 0,1,1,0
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("part_cnt", 32'(m_cnt), 32'h2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("part_clr_cnt", 32'(m_cnt), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("part_dout_msb", 32'(m_dout), 32'h6);
        chk("part_dout_lsb", 32'(l_dout), 32'h6);
        chk("part_dvalid", 32'(m_dvalid), 32'h1);

        // Reset after 3 bits with a word pending
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("mrst_q", 32'(m_q), 32'h0);
        chk("mrst_cnt", 32'(m_cnt), 32'h0);
        chk("mrst_dout", 32'(m_dout), 32'h0);
        chk("mrst_dvalid", 32'(m_dvalid), 32'h0);
        chk("mrst_ovr", 32'(m_ovr), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_dout_msb", 32'(m_dout), 32'hC);
        chk("post_dout_lsb", 32'(l_dout), 32'h3);
        chk("post_dvalid", 32'(m_dvalid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-in/parallel-out deserialiser, the next generation of the team's fixed 4-bit SIPO register. It shifts one bit per enabled clock into a WIDTH-bit register with selectable bit order, and counts bits to frame words. It presents each completed word on a held output with a valid/ready handshake and a sticky overrun flag. It sits between a serial line front-end and any parallel word consumer.

## Interface
- WIDTH, 8: word length in bits, ≥2.
- LSB_FIRST, 0: 0 means first received bit lands in DOUT[WIDTH-1]; 1 means first received bit lands in DOUT[0].
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- EN  in  1  bit strobe; IN is sampled only on edges where EN=1.
- IN  in  1  serial data bit.
- CLR  in  1  synchronous frame restart; discards the partial word.
- Q  out  WIDTH  live shift register contents.
- BITCNT  out  $clog2(WIDTH)  bits received in the current word, 0..WIDTH-1.
- DOUT  out  WIDTH  last completed word, held until consumed.
- DVALID  out  1  DOUT holds an unconsumed word.
- DREADY  in  1  consumer accepts DOUT on an edge where DVALID=1 and DREADY=1.
- OVR  out  1  sticky overrun: a word completed while the previous word was still unconsumed.

## Operation
- Shift on EN=1 and CLR=0:
  - LSB_FIRST=0: Q <= {Q[WIDTH-2:0], IN}.
  - LSB_FIRST=1: Q <= {IN, Q[WIDTH-1:1]}.
- Counter: on each shift, BITCNT increments. At BITCNT=WIDTH-1 the shift completes a word, and BITCNT wraps to 0.
- Word completion (the shift with BITCNT=WIDTH-1) depends on the handshake state:
  - DVALID=0: DOUT <= post-shift Q value, which includes the current IN; DVALID <= 1.
  - DVALID=1 and DREADY=1 on the same edge: the old word is consumed and the new word is loaded. DOUT <= new word, DVALID stays 1, no overrun.
  - DVALID=1 and DREADY=0: the new word is dropped, DOUT is unchanged, DVALID stays 1, OVR <= 1.
- Handshake with no completion: DVALID=1 and DREADY=1 gives DVALID <= 0, and DOUT keeps its stale value.
- DREADY is ignored while DVALID=0.
- CLR=1 has priority over EN:
  - Q <= 0, BITCNT <= 0, OVR <= 0, and the IN bit on that edge is discarded.
  - DOUT and DVALID are unaffected, and a handshake on the same edge still completes.
- EN=0: Q and BITCNT hold.
- Reset is synchronous, with priority over everything. After reset Q=0, BITCNT=0, DOUT=0, DVALID=0, OVR=0. Reset mid-word discards partial data and any pending word.

## Timing
- Latency: the last bit of a word sampled at edge k gives DOUT valid and DVALID=1 immediately after edge k (zero added cycles).
- Minimum word period is WIDTH enabled edges. Back-to-back words with EN held high complete every WIDTH cycles.
- To sustain throughput without overrun, the consumer must assert DREADY within WIDTH-1 cycles of DVALID rising.
- OVR rises on the edge of the dropped completion. It clears only by RST or CLR.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package sipo_pkg holds:
  - the default WIDTH constant;
  - a count-width function returning $clog2 with a minimum of 1;
  - the bit-order encoding constants MSB_FIRST=0 and LSB_FIRST=1.
- One sub-module is natural: sipo_shift_core, containing the shift register, bit counter and word-complete strobe.
- The top level adds the DOUT holding register, the valid/ready handshake and OVR.

## Test plan
- WIDTH=4, LSB_FIRST=0, EN=1, IN=1,0,1,1 -> DOUT=4'b1011 and DVALID=1 after the 4th edge; BITCNT=0.
- WIDTH=4, LSB_FIRST=1, same stream -> DOUT=4'b1101.
- Backpressure: DREADY=0, send 1010 then 0101 -> DOUT stays 1010, DVALID=1, OVR=1. Then DREADY=1 for one edge -> DVALID=0, OVR remains 1.
- Simultaneous events, with a word pending:
  - DREADY=1 on the edge that completes 0011 -> DOUT=0011, DVALID=1, OVR=0.
  - Separately, CLR and EN on the same edge -> bit discarded, BITCNT=0.
- CLR mid-word: send 1,1, then CLR, then 0,1,1,0 -> DOUT=0110, no stray bits.
- RST asserted after 3 bits with a word pending -> next edge all outputs 0. The following 4 bits form a clean word.
